// File: rtl/constraint_check_pipe.sv
// constraint_check_pipe: streaming constraint checker.
// Each candidate carries NUM_VARS variables of VAR_W bits. Enabled variables
// are tested against a 2-bit predicate and the results are combined by AND
// or OR into one satisfied bit. Two register stages with per-stage valids
// and a global stall; saturating counts of accepted and satisfying candidates.
// Optional feature macro: CONSTRAINT_STICKY_EN adds first_unsat_valid and
// first_unsat_tag, capturing the tag of the first unsatisfied result emitted.
module constraint_check_pipe #(
  parameter int NUM_VARS = 4,
  parameter int VAR_W    = 16,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_VARS*VAR_W-1:0] in_vars,
  input  logic [2*NUM_VARS-1:0]     cfg_op,
  input  logic [NUM_VARS-1:0]       cfg_en,
  input  logic                      cfg_mode,
  input  logic                      clr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sat,
  output logic [CNT_W-1:0]          out_tag,
  output logic [CNT_W-1:0]          sat_count,
`ifdef CONSTRAINT_STICKY_EN
  output logic [CNT_W-1:0]          total_count,
  output logic                      first_unsat_valid,
  output logic [CNT_W-1:0]          first_unsat_tag
`else
  output logic [CNT_W-1:0]          total_count
`endif
);

  // Predicate on one variable: 00 nonzero, 01 zero, 10 all-ones, 11 not all-ones.
  function automatic logic pred_eval(input logic [1:0] op, input logic [VAR_W-1:0] v);
    logic any_set;
    logic all_set;
    any_set = |v;
    all_set = &v;
    case (op)
      2'b00:   return any_set;
      2'b01:   return ~any_set;
      2'b10:   return all_set;
      default: return ~all_set;
    endcase
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic                vld_p1_q, vld_p1_d;
  logic [NUM_VARS-1:0] pred_p1_q, pred_p1_d;
  logic                mode_p1_q, mode_p1_d;
  logic [CNT_W-1:0]    tag_p1_q, tag_p1_d;
  logic                vld_p2_q, vld_p2_d;
  logic                sat_p2_q, sat_p2_d;
  logic [CNT_W-1:0]    tag_p2_q, tag_p2_d;
  logic [CNT_W-1:0]    total_q, total_d;
  logic [CNT_W-1:0]    sat_cnt_q, sat_cnt_d;
  logic                s2_advance, accept, emit;

  assign s2_advance  = ~vld_p2_q | out_ready;
  assign in_ready    = ~vld_p1_q | s2_advance;
  assign accept      = in_valid & in_ready;
  assign emit        = vld_p2_q & out_ready;
  assign out_valid   = vld_p2_q;
  assign out_sat     = sat_p2_q;
  assign out_tag     = tag_p2_q;
  assign sat_count   = sat_cnt_q;
  assign total_count = total_q;

  // Stage 1 next state: evaluate predicates of an accepted candidate with its own config.
  always_comb begin
    vld_p1_d  = vld_p1_q;
    pred_p1_d = pred_p1_q;
    mode_p1_d = mode_p1_q;
    tag_p1_d  = tag_p1_q;
    if (accept) begin
      vld_p1_d  = 1'b1;
      mode_p1_d = cfg_mode;
      tag_p1_d  = total_q;
      for (int i = 0; i < NUM_VARS; i++) begin
        // A disabled variable takes the identity value of the combine operator.
        pred_p1_d[i] = cfg_en[i] ? pred_eval(cfg_op[2*i +: 2], in_vars[i*VAR_W +: VAR_W])
                                 : ~cfg_mode;
      end
    end else if (s2_advance) begin
      vld_p1_d = 1'b0;
    end
  end

  // Stage 2 next state: combine predicates into the output slot when it can move.
  always_comb begin
    vld_p2_d = vld_p2_q;
    sat_p2_d = sat_p2_q;
    tag_p2_d = tag_p2_q;
    if (s2_advance) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        sat_p2_d = mode_p1_q ? (|pred_p1_q) : (&pred_p1_q);
        tag_p2_d = tag_p1_q;
      end
    end
  end

  // Counter next state: clear has priority over any increment in the same cycle.
  always_comb begin
    total_d   = total_q;
    sat_cnt_d = sat_cnt_q;
    if (clr) begin
      total_d   = '0;
      sat_cnt_d = '0;
    end else begin
      if (accept)            total_d   = sat_inc(total_q);
      if (emit && sat_p2_q)  sat_cnt_d = sat_inc(sat_cnt_q);
    end
  end

  // ---- stage 1 boundary: control ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1_q <= 1'b0;
    else        vld_p1_q <= vld_p1_d;
  end

  // Stage 1 data registers carry no reset; they are qualified by vld_p1_q.
  always_ff @(posedge clk) begin
    pred_p1_q <= pred_p1_d;
    mode_p1_q <= mode_p1_d;
    tag_p1_q  <= tag_p1_d;
  end

  // ---- stage 2 boundary: output slot, reset so outputs read zero ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2_q <= 1'b0;
      sat_p2_q <= 1'b0;
      tag_p2_q <= '0;
    end else begin
      vld_p2_q <= vld_p2_d;
      sat_p2_q <= sat_p2_d;
      tag_p2_q <= tag_p2_d;
    end
  end

  // Accepted and satisfying candidate counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q   <= '0;
      sat_cnt_q <= '0;
    end else begin
      total_q   <= total_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

`ifdef CONSTRAINT_STICKY_EN
  logic             fu_valid_q, fu_valid_d;
  logic [CNT_W-1:0] fu_tag_q, fu_tag_d;

  assign first_unsat_valid = fu_valid_q;
  assign first_unsat_tag   = fu_tag_q;

  // Sticky capture of the first unsatisfied tag emitted since reset or clear.
  always_comb begin
    fu_valid_d = fu_valid_q;
    fu_tag_d   = fu_tag_q;
    if (clr) begin
      fu_valid_d = 1'b0;
      fu_tag_d   = '0;
    end else if (emit && !sat_p2_q && !fu_valid_q) begin
      fu_valid_d = 1'b1;
      fu_tag_d   = tag_p2_q;
    end
  end

  // Sticky capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fu_valid_q <= 1'b0;
      fu_tag_q   <= '0;
    end else begin
      fu_valid_q <= fu_valid_d;
      fu_tag_q   <= fu_tag_d;
    end
  end
`endif

endmodule

// File: tb/tb_constraint_check_pipe.sv
// Testbench for constraint_check_pipe: a 16-bit-counter instance and a 4-bit-
// counter instance share all inputs. A queue-based model checks every cycle;
// hand vectors and sequences cover latency, stall, saturation, clear and reset.
// Builds with or without CONSTRAINT_STICKY_EN.
module tb_constraint_check_pipe;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, cfg_mode, clr, out_ready;
  logic [63:0] in_vars;
  logic [7:0]  cfg_op;
  logic [3:0]  cfg_en;
  logic        in_ready, out_valid, out_sat;
  logic [15:0] out_tag, sat_count, total_count;
  logic        in_ready_s, out_valid_s, out_sat_s;
  logic [3:0]  out_tag_s, sat_count_s, total_count_s;
`ifdef CONSTRAINT_STICKY_EN
  logic        fu_valid, fu_valid_s;
  logic [15:0] fu_tag;
  logic [3:0]  fu_tag_s;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  constraint_check_pipe #(.NUM_VARS(4), .VAR_W(16), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_vars(in_vars), .cfg_op(cfg_op), .cfg_en(cfg_en), .cfg_mode(cfg_mode),
    .clr(clr), .out_valid(out_valid), .out_ready(out_ready), .out_sat(out_sat),
    .out_tag(out_tag), .sat_count(sat_count),
`ifdef CONSTRAINT_STICKY_EN
    .total_count(total_count), .first_unsat_valid(fu_valid), .first_unsat_tag(fu_tag)
`else
    .total_count(total_count)
`endif
  );

  constraint_check_pipe #(.NUM_VARS(4), .VAR_W(16), .CNT_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_vars(in_vars), .cfg_op(cfg_op), .cfg_en(cfg_en), .cfg_mode(cfg_mode),
    .clr(clr), .out_valid(out_valid_s), .out_ready(out_ready), .out_sat(out_sat_s),
    .out_tag(out_tag_s), .sat_count(sat_count_s),
`ifdef CONSTRAINT_STICKY_EN
    .total_count(total_count_s), .first_unsat_valid(fu_valid_s), .first_unsat_tag(fu_tag_s)
`else
    .total_count(total_count_s)
`endif
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: count enabled predicates that hold, then apply AND/OR semantics.
  function automatic bit model_sat(input logic [63:0] vars, input logic [7:0] op,
                                   input logic [3:0] en, input bit mode);
    int n_en = 0;
    int n_true = 0;
    for (int i = 0; i < 4; i++) begin
      if (en[i]) begin
        logic [15:0] v;
        logic [1:0]  o;
        bit          r;
        v = vars[i*16 +: 16];
        o = op[2*i +: 2];
        case (o)
          2'd0:    r = (v != 16'h0);
          2'd1:    r = (v == 16'h0);
          2'd2:    r = (v == 16'hFFFF);
          default: r = (v != 16'hFFFF);
        endcase
        n_en++;
        if (r) n_true++;
      end
    end
    return mode ? (n_true > 0) : (n_true == n_en);
  endfunction

  function automatic int satv(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  typedef struct {
    bit sat;
    int tag;
    int cyc;
  } ent_t;

  ent_t q[$];
  int   tot = 0, satc = 0, mon_cyc = 0;
  bit   fu_v = 0;
  int   fu_t = 0;

  // Cycle monitor: compare against the model, then predict the coming edge.
  always @(negedge clk) begin : mon
    bit   exp_ov, exp_ir, acc, emit;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      tot = 0; satc = 0; fu_v = 0; fu_t = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_total", total_count, 0);
      chk("rst_satcnt", sat_count, 0);
      chk("rst_out_valid_s", out_valid_s, 0);
      chk("rst_total_s", total_count_s, 0);
    end else begin
      // Capacity two; the oldest entry is visible from its second cycle on.
      exp_ov = (q.size() > 0) && (mon_cyc >= q[0].cyc + 2);
      exp_ir = (q.size() < 2) || out_ready;
      chk("in_ready", in_ready, exp_ir);
      chk("in_ready_s", in_ready_s, exp_ir);
      chk("out_valid", out_valid, exp_ov);
      chk("out_valid_s", out_valid_s, exp_ov);
      if (exp_ov) begin
        chk("out_sat", out_sat, q[0].sat);
        chk("out_tag", out_tag, satv(q[0].tag, 65535));
        chk("out_sat_s", out_sat_s, q[0].sat);
        chk("out_tag_s", out_tag_s, satv(q[0].tag, 15));
      end
      chk("total_count", total_count, satv(tot, 65535));
      chk("sat_count", sat_count, satv(satc, 65535));
      chk("total_count_s", total_count_s, satv(tot, 15));
      chk("sat_count_s", sat_count_s, satv(satc, 15));
`ifdef CONSTRAINT_STICKY_EN
      chk("fu_valid", fu_valid, fu_v);
      chk("fu_tag", fu_tag, satv(fu_t, 65535));
      chk("fu_valid_s", fu_valid_s, fu_v);
      chk("fu_tag_s", fu_tag_s, satv(fu_t, 15));
`endif
      acc  = in_valid && exp_ir;
      emit = exp_ov && out_ready;
      if (emit) begin
        e = q.pop_front();
        if (e.sat) satc++;
        else if (!fu_v) begin fu_v = 1; fu_t = e.tag; end
      end
      if (acc) begin
        e.sat = model_sat(in_vars, cfg_op, cfg_en, cfg_mode);
        e.tag = tot;
        e.cyc = mon_cyc;
        q.push_back(e);
        tot++;
      end
      if (clr) begin tot = 0; satc = 0; fu_v = 0; fu_t = 0; end
      mon_cyc++;
    end
  end

  typedef struct {
    logic [63:0] vars;
    logic [7:0]  op;
    logic [3:0]  en;
    bit          mode;
    bit          exp;
  } vec_t;

  vec_t vecs[10];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cand(input logic [63:0] v, input logic [7:0] op,
                          input logic [3:0] en, input bit mode);
    in_vars = v; cfg_op = op; cfg_en = en; cfg_mode = mode;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int idx, got, spur;
    int tags[$];

    vecs[0] = '{64'h0001_0001_0001_0001, 8'h00, 4'hF, 1'b0, 1'b1};
    vecs[1] = '{64'h0000_FFFF_0000_0000, 8'h20, 4'b0100, 1'b1, 1'b1};
    vecs[2] = '{64'h0000_FFFE_0000_0000, 8'h20, 4'b0100, 1'b1, 1'b0};
    vecs[3] = '{64'h0000_0000_0000_0000, 8'h00, 4'h0, 1'b0, 1'b1};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 4'h0, 1'b1, 1'b0};
    vecs[5] = '{64'h0001_0001_0000_0001, 8'h00, 4'hF, 1'b0, 1'b0};
    vecs[6] = '{64'h0000_0000_0000_0000, 8'h55, 4'hF, 1'b0, 1'b1};
    vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 4'hF, 1'b1, 1'b0};
    vecs[8] = '{64'hFFFF_FFFF_FFFF_7FFF, 8'hFF, 4'hF, 1'b1, 1'b1};
    vecs[9] = '{64'hFFFF_0000_0000_0001, 8'h80, 4'b1001, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
    set_cand(64'h0, 8'h0, 4'h0, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // First candidate after reset: latency, tag and counters.
    cyc();
    set_cand(64'h0001_0001_0001_0001, 8'h00, 4'hF, 1'b0);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_not_yet", out_valid, 0);
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    chk("lat_sat", out_sat, 1);
    chk("lat_tag", out_tag, 0);
    chk("lat_total", total_count, 1);
    @(negedge clk);
    chk("lat_satcnt", sat_count, 1);

    // Table of single candidates with hand-computed results.
    for (int k = 0; k < 10; k++) begin
      cyc();
      set_cand(vecs[k].vars, vecs[k].op, vecs[k].en, vecs[k].mode);
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      got = 0;
      for (int w = 0; w < 10 && got == 0; w++) begin
        @(negedge clk);
        if (out_valid) got = 1;
      end
      chk($sformatf("vec%0d_seen", k), got, 1);
      chk($sformatf("vec%0d_sat", k), out_sat, vecs[k].exp);
    end

    // Stall: five candidates offered against a blocked collector.
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 5);
      set_cand({48'h0, 16'(idx + 1)}, 8'h00, 4'h1, 1'b0);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      cyc();
    end
    chk("stall_accepted", idx, 2);
    @(negedge clk);
    chk("stall_in_ready", in_ready, 0);
    cyc();
    out_ready = 1'b1;
    for (int c = 0; c < 30 && tags.size() < 5; c++) begin
      in_valid = (idx < 5);
      set_cand({48'h0, 16'(idx + 1)}, 8'h00, 4'h1, 1'b0);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (out_valid) tags.push_back(int'(out_tag));
      cyc();
    end
    in_valid = 1'b0;
    chk("stall_count", tags.size(), 5);
    for (int i = 0; i < tags.size(); i++) chk($sformatf("stall_tag%0d", i), tags[i], i);

    // Saturation of the narrow counters, then clear against a simultaneous accept.
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    set_cand(64'h0001_0001_0001_0001, 8'h00, 4'hF, 1'b0);
    in_valid = 1'b1;
    repeat (20) cyc();
    in_valid = 1'b0;
    repeat (4) cyc();
    @(negedge clk);
    chk("sat_total_s", total_count_s, 4'hF);
    chk("sat_satcnt_s", sat_count_s, 4'hF);
    chk("sat_total", total_count, 20);
    chk("sat_satcnt", sat_count, 20);
    cyc();
    in_valid = 1'b1;
    clr = 1'b1;
    cyc();
    in_valid = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    chk("clr_acc_total", total_count, 0);
    chk("clr_acc_total_s", total_count_s, 0);
    repeat (4) cyc();

    // Random traffic, config and backpressure.
    for (int r = 0; r < 400; r++) begin
      logic [63:0] v;
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 3))
          0:       v[i*16 +: 16] = 16'h0000;
          1:       v[i*16 +: 16] = 16'hFFFF;
          2:       v[i*16 +: 16] = 16'($urandom);
          default: v[i*16 +: 16] = 16'h0001;
        endcase
      end
      set_cand(v, 8'($urandom), 4'($urandom), 1'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      clr       = ($urandom_range(0, 39) == 0);
      cyc();
    end
    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();

`ifdef CONSTRAINT_STICKY_EN
    // Sticky capture: sat, sat, unsat, unsat records tag 2.
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    in_valid = 1'b1;
    set_cand(64'h0001_0001_0001_0001, 8'h00, 4'hF, 1'b0); cyc();
    set_cand(64'h0001_0001_0001_0001, 8'h00, 4'hF, 1'b0); cyc();
    set_cand(64'h0000_0000_0000_0000, 8'h00, 4'hF, 1'b0); cyc();
    set_cand(64'h0000_0000_0000_0000, 8'h00, 4'hF, 1'b0); cyc();
    in_valid = 1'b0;
    repeat (4) cyc();
    @(negedge clk);
    chk("sticky_valid", fu_valid, 1);
    chk("sticky_tag", fu_tag, 2);
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    @(negedge clk);
    chk("sticky_clr_valid", fu_valid, 0);
    chk("sticky_clr_tag", fu_tag, 0);
    cyc();
`endif

    // Asynchronous reset with two candidates in flight.
    out_ready = 1'b0;
    set_cand(64'h0001_0001_0001_0001, 8'h00, 4'hF, 1'b0);
    in_valid = 1'b1;
    cyc();
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_sat", out_sat, 0);
    chk("arst_out_tag", out_tag, 0);
    chk("arst_total", total_count, 0);
    chk("arst_satcnt", sat_count, 0);
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    out_ready = 1'b1;
    spur = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid || out_valid_s) spur++;
    end
    chk("post_rst_spurious", spur, 0);
    chk("post_rst_in_ready", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
